// File: rtl/uart_pkg.sv
// Purpose: shared UART constants and the TX feeder state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: BYTE_W data width, DEF_DEPTH default buffer depth, feeder_state_t.
package uart_pkg;

  localparam int BYTE_W    = 8;
  // Default buffer depth; the RX-side buffer is expected to reuse it.
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Purpose: bundles the CPU write side and the transmitter handshake of the TX feeder.
// Latency: n/a (wires only).
// Backpressure: full/overflow toward the writer, tx_busy from the transmitter.
// Ports: slave = feeder view, master = environment (CPU + transmitter) view.
interface uart_tx_feeder_if #(
  parameter int DEPTH = uart_pkg::DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
);

  logic [uart_pkg::BYTE_W-1:0] wr_data;
  logic                        wr_en;
  logic                        full;
  logic                        empty;
  logic [AW:0]                 count;
  logic                        overflow;
  logic                        ovf_clr;
  logic [uart_pkg::BYTE_W-1:0] sdata;
  logic                        tx_start;
  logic                        tx_busy;

  modport slave (
    input  wr_data, wr_en, ovf_clr, tx_busy,
    output full, empty, count, overflow, sdata, tx_start
  );

  modport master (
    output wr_data, wr_en, ovf_clr, tx_busy,
    input  full, empty, count, overflow, sdata, tx_start
  );

endinterface

// File: rtl/uart_tx_feeder_byte_fifo.sv
// Purpose: synchronous byte FIFO with registered count/full/empty.
// Latency: write visible in count/empty the cycle after the write edge; rd_data is mem[rd_ptr] combinationally.
// Backpressure: writes while full are ignored; pops while empty are ignored.
// Ports: clk, reset_n, wr_en/wr_data, rd_en/rd_data, count, full, empty.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = BYTE_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [AW:0]   count_nxt;

  // Acceptance uses the registered (pre-edge) full/empty, so a write while
  // full is dropped even if a pop frees a slot on the same edge.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (pop && !push) begin
      count_nxt = count - 1'b1;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Purpose: buffers CPU bytes and issues them one at a time to the UART transmitter.
// Latency: write into empty FIFO with idle transmitter -> tx_start 2 cycles later; next start 2 cycles after tx_busy falls.
// Backpressure: full flags the writer, dropped writes set sticky overflow; tx_busy stalls issue.
// Ports: clk, reset_n, bus (uart_tx_feeder_if.slave: wr_*, full/empty/count, overflow/ovf_clr, sdata/tx_start/tx_busy).
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  uart_tx_feeder_if.slave       bus
);

  feeder_state_t       state;
  logic                pop;
  logic [BYTE_W-1:0]   rd_data;
  logic [AW:0]         fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [BYTE_W-1:0]   sdata_q;
  logic                tx_start_q;
  logic                overflow_q;

  // A byte is taken only from IDLE, so sdata never changes while the
  // transmitter may still be sampling the previous byte.
  assign pop = (state == IDLE) && !fifo_empty && !bus.tx_busy;

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // WAIT_BUSY absorbs the registered tx_busy latency: the transmitter only
  // raises busy the cycle after it sees tx_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sdata_q    <= '0;
      tx_start_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sdata_q    <= rd_data;
            tx_start_q <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          tx_start_q <= 1'b0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            state <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          tx_start_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky drop flag; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (bus.wr_en && fifo_full) begin
      overflow_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.count    = fifo_count;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.overflow = overflow_q;
  assign bus.sdata    = sdata_q;
  assign bus.tx_start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Purpose: self-checking bench for uart_tx_feeder with a queue-based reference model.
// Latency: n/a.
// Backpressure: bench transmitter holds tx_busy for a chosen number of cycles after each start.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the buffer is a plain queue; issue timing is tracked
  // as timestamps (cycle of last start, first busy-high after it, first
  // busy-low after that).
  logic [7:0] mq[$];
  logic       m_ovf;
  logic [7:0] m_sdata;
  logic       m_start;
  int         cyc;
  int         last_start;
  int         busy_hi;
  int         busy_lo;

  // Bench transmitter and scenario knobs.
  int   busy_left;
  logic hold_busy;
  int   busy_len_fixed;
  int   foreign_pct;

  // Observed start pulses.
  int         st_cyc[$];
  logic [7:0] st_dat[$];
  logic [7:0] wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf      = 1'b0;
    m_sdata    = 8'h00;
    m_start    = 1'b0;
    cyc        = 0;
    last_start = -1;
    busy_hi    = -1;
    busy_lo    = -1;
    busy_left  = 0;
    hold_busy  = 1'b0;
  endtask

  function automatic bit model_quiet();
    return (mq.size() == 0) && !m_start && (busy_left == 0) && !hold_busy &&
           (last_start < 0 || busy_lo >= 0);
  endfunction

  // One clock cycle: compare outputs against the model, drive inputs,
  // advance the model across the closing edge.
  task automatic cycle(input logic we, input logic [7:0] wd, input logic clr);
    logic busy_c;
    bit   eligible;
    bit   pop;
    bit   full_pre;
    chk("count",    32'(bus.count), mq.size());
    chk("full",     bus.full,       mq.size() == DEPTH);
    chk("empty",    bus.empty,      mq.size() == 0);
    chk("overflow", bus.overflow,   m_ovf);
    chk("tx_start", bus.tx_start,   m_start);
    chk("sdata",    bus.sdata,      m_sdata);
    if (bus.tx_start === 1'b1) begin
      st_cyc.push_back(cyc);
      st_dat.push_back(bus.sdata);
    end

    // Transmitter: a start seen this cycle makes busy high from next cycle.
    busy_c = hold_busy || (busy_left > 0);
    if (busy_left > 0) busy_left--;
    if (m_start) begin
      busy_left = (busy_len_fixed > 0) ? busy_len_fixed : int'($urandom_range(1, 12));
    end else if (busy_left == 0 && foreign_pct > 0 && int'($urandom_range(0, 99)) < foreign_pct) begin
      busy_left = $urandom_range(1, 4);
    end

    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.ovf_clr = clr;
    bus.tx_busy = busy_c;

    // After a start, the feeder must see busy high, then busy low, and only
    // the cycle after that low may it take the next byte.
    if (last_start >= 0) begin
      if (busy_hi < 0) begin
        if (busy_c && cyc > last_start) busy_hi = cyc;
      end else if (busy_lo < 0 && !busy_c) begin
        busy_lo = cyc;
      end
    end
    eligible = (last_start < 0) || (busy_lo >= 0 && cyc > busy_lo);
    full_pre = (mq.size() == DEPTH);
    pop      = eligible && (mq.size() > 0) && !busy_c;
    if (pop) begin
      m_sdata    = mq.pop_front();
      last_start = cyc + 1;
      busy_hi    = -1;
      busy_lo    = -1;
    end
    if (we && !full_pre) mq.push_back(wd);
    if (we && full_pre) m_ovf = 1'b1;
    else if (clr)       m_ovf = 1'b0;

    @(posedge clk);
    #1;
    cyc++;
    m_start = pop;
  endtask

  task automatic run_idle(input int max_cyc);
    int n;
    n = 0;
    while (!model_quiet() && n < max_cyc) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    if (!model_quiet()) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: still active after %0d cycles, required quiet", max_cyc);
    end
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_stream(input string name, input int exp_n);
    chk({name, "_len"}, st_dat.size(), exp_n);
    for (int i = 0; i < st_dat.size() && i < wq.size(); i++) begin
      chk(name, st_dat[i], wq[i]);
    end
  endtask

  initial begin
    logic [7:0] d;
    int         wp;
    int         n;
    bus.wr_en      = 1'b0;
    bus.wr_data    = 8'h00;
    bus.ovf_clr    = 1'b0;
    bus.tx_busy    = 1'b0;
    foreign_pct    = 0;
    busy_len_fixed = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset values.
    chk("rst_count",    32'(bus.count), 0);
    chk("rst_full",     bus.full,       0);
    chk("rst_empty",    bus.empty,      1);
    chk("rst_overflow", bus.overflow,   0);
    chk("rst_sdata",    bus.sdata,      8'h00);
    chk("rst_tx_start", bus.tx_start,   0);

    // Single byte: start in cycle 2 only, busy held cycles 3..20.
    busy_len_fixed = 18;
    cycle(1'b1, 8'hA5, 1'b0);
    chk("a5_no_early", bus.tx_start, 0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("a5_start", bus.tx_start, 1);
    chk("a5_sdata", bus.sdata, 8'hA5);
    cycle(1'b0, 8'h00, 1'b0);
    chk("a5_one_cycle", bus.tx_start, 0);
    repeat (19) cycle(1'b0, 8'h00, 1'b0);
    chk("a5_empty_after", bus.empty, 1);
    chk("a5_sdata_held", bus.sdata, 8'hA5);
    run_idle(100);

    // Back-to-back 01..05, busy 10 cycles per byte; second write meets the first pop.
    busy_len_fixed = 10;
    st_cyc.delete();
    st_dat.delete();
    cycle(1'b1, 8'h01, 1'b0);
    cycle(1'b1, 8'h02, 1'b0);
    chk("wr_pop_count", 32'(bus.count), 1);
    chk("wr_pop_empty", bus.empty, 0);
    for (int i = 3; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0);
    run_idle(300);
    chk("b2b_pulses", st_dat.size(), 5);
    for (int i = 0; i < st_dat.size() && i < 5; i++) chk("b2b_data", st_dat[i], 8'(i + 1));
    for (int i = 1; i < st_cyc.size() && i < 5; i++) chk("b2b_gap", st_cyc[i] - st_cyc[i-1], 13);

    // Overflow: busy held, DEPTH+1 writes; 17th write coincides with a clear.
    hold_busy      = 1'b1;
    busy_len_fixed = 2;
    wq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      wq.push_back(d);
      cycle(1'b1, d, 1'b0);
    end
    chk("ovf_full",   bus.full, 1);
    chk("ovf_count",  32'(bus.count), 16);
    chk("ovf_before", bus.overflow, 0);
    cycle(1'b1, 8'($urandom), 1'b1);
    chk("ovf_set_wins", bus.overflow, 1);
    chk("ovf_count_17", 32'(bus.count), 16);
    cycle(1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", bus.overflow, 0);
    hold_busy = 1'b0;
    st_dat.delete();
    run_idle(600);
    check_stream("ovf_stream", DEPTH);

    // Wrap: fill, drain down to 6, refill with 10.
    hold_busy = 1'b1;
    wq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      d = 8'($urandom);
      wq.push_back(d);
      cycle(1'b1, d, 1'b0);
    end
    hold_busy      = 1'b0;
    busy_len_fixed = 3;
    st_dat.delete();
    n = 0;
    while (mq.size() > 6 && n < 500) begin
      cycle(1'b0, 8'h00, 1'b0);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      wq.push_back(d);
      cycle(1'b1, d, 1'b0);
    end
    run_idle(600);
    check_stream("wrap_stream", DEPTH + 10);

    // Randomized traffic with varying write rate and foreign busy pulses.
    busy_len_fixed = 0;
    foreign_pct    = 3;
    for (int seg = 0; seg < 10; seg++) begin
      wp = $urandom_range(5, 60);
      for (int i = 0; i < 200; i++) begin
        cycle(int'($urandom_range(0, 99)) < wp, 8'($urandom), int'($urandom_range(0, 99)) < 4);
      end
    end
    foreign_pct = 0;
    run_idle(1000);

    // Reset while waiting for busy to drop, with 3 bytes queued.
    busy_len_fixed = 10;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 3);
    #2;
    reset_n     = 1'b0;
    bus.tx_busy = 1'b0;
    #1;
    chk("arst_count",    32'(bus.count), 0);
    chk("arst_empty",    bus.empty,      1);
    chk("arst_tx_start", bus.tx_start,   0);
    chk("arst_sdata",    bus.sdata,      8'h00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    st_cyc.delete();
    st_dat.delete();
    repeat (30) cycle(1'b0, 8'h00, 1'b0);
    chk("no_start_after_rst", st_cyc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte buffer and issue controller that sits directly upstream of the UART transmitter.
- Accepts bytes from the CPU/MMIO side into a power-of-two FIFO.
- Hands bytes one at a time to the transmitter through its sdata/tx_start/tx_busy handshake.
- Prevents lost bytes when software writes faster than the line rate.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wr_data  in  8  byte to enqueue
- wr_en  in  1  enqueue strobe, one byte per cycle
- full  out  1  FIFO full (count == DEPTH)
- empty  out  1  FIFO empty (count == 0)
- count  out  AW+1  bytes currently buffered
- overflow  out  1  sticky: a write was dropped while full
- ovf_clr  in  1  clears overflow
- sdata  out  8  byte to transmitter
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_busy  in  1  transmitter busy, registered on transmitter side

Behaviour:
- Reset: asynchronous, all state cleared.
  - Outputs after reset: full=0, empty=1, count=0, overflow=0, sdata=8'h00, tx_start=0.
  - State is IDLE; rd_ptr=wr_ptr=0.
- Write:
  - When wr_en=1 and full=0, wr_data is stored at wr_ptr and wr_ptr increments (wraps mod DEPTH).
  - full is evaluated on the pre-edge count. A write while full is dropped even if a pop happens in the same cycle, and sets overflow.
- Overflow flag:
  - overflow stays 1 until ovf_clr.
  - If ovf_clr and a dropped write coincide, set wins.
- count:
  - +1 on accepted write, -1 on pop, unchanged when both occur.
  - full and empty are registered, consistent with count every cycle.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
  - IDLE -> START when empty=0 and tx_busy=0.
    - On that edge: sdata <= mem[rd_ptr], tx_start <= 1, rd_ptr++, count--.
  - START -> WAIT_BUSY unconditionally; tx_start <= 0.
    - tx_start is exactly one cycle wide.
  - WAIT_BUSY -> WAIT_DONE when tx_busy=1.
    - Covers the one-cycle registered latency of tx_busy after tx_start.
  - WAIT_DONE -> IDLE when tx_busy=0.
- sdata holds its value from the pop until the next pop; it is never changed while the transmitter may sample it.
- Latency:
  - wr_en into an empty FIFO with idle transmitter -> tx_start asserted 2 cycles later.
  - Back-to-back bytes: next tx_start occurs 2 cycles after tx_busy falls (IDLE sees tx_busy=0, then pulse).
- tx_busy already 1 in IDLE (foreign start): no pop until it drops.
- Wrap-around: pointers wrap at DEPTH-1 -> 0. Data order is strictly FIFO across the wrap.
- Simultaneous write and pop with count=1: count stays 1, empty stays 0, the new byte is next.
- Reset mid-transfer: buffered bytes are discarded. tx_start drops immediately. No retry of the in-flight byte.

Decomposition:
- Package uart_pkg holds:
  - BYTE_W = 8
  - typedef enum logic [1:0] feeder_state_t {IDLE, START, WAIT_BUSY, WAIT_DONE}
  - Default DEPTH constant, shared with a future RX-side buffer.
- One sub-module: byte_fifo (synchronous FIFO, DEPTH/AW parameters).
  - Signals: wr_en/wr_data/rd_en/rd_data/count/full/empty.
  - Reusable for the receive path.
- The top level holds only the FSM, the sdata/tx_start registers and overflow.

Test Plan:
- Single byte 8'hA5 written at cycle 0 with tx_busy=0:
  - tx_start=1 only in cycle 2, sdata=8'hA5.
  - Bench pulls tx_busy high cycle 3..20 -> state returns to IDLE at cycle 21, empty=1.
- Write 8'h01..8'h05 back-to-back with a transmitter model (busy 10 cycles after each start):
  - Five tx_start pulses with sdata 01,02,03,04,05 in order.
  - Each pulse is 2 cycles after the previous busy fall.
- Hold tx_busy=1, write DEPTH+1 bytes (16+1):
  - full=1 after 16, count=16, overflow=1, 17th byte absent from output stream.
  - ovf_clr -> overflow=0.
- Fill to 16, drain 10, write 10 more (pointer wrap):
  - Output sequence matches write order exactly, count never exceeds 16.
- Simultaneous wr_en and pop at count=1: count remains 1, next sdata equals the newly written byte.
- Assert reset_n low in WAIT_DONE with 3 bytes queued:
  - Asynchronously count=0, empty=1, tx_start=0, sdata=8'h00.
  - After release, no tx_start without new writes.
